// File: rtl/npu_cmd_issuer.sv
// npu_cmd_issuer: host-side command sequencer in front of the NPU slave port.
// Commands (WRITE/READ/POLL/reserved) arrive on a valid/ready stream, are
// buffered in a small FIFO and executed strictly in order, one NPU bus access
// at a time. READ/POLL results and errors leave on a valid/ready response
// stream.
// Optional feature macro: NPU_CMD_ISSUER_PERF_EN adds saturating busy-cycle
// and popped-command counters (perf_busy_cycles_o, perf_cmds_o).
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both 1. Once raised, rsp_valid_o keeps its data
// and error stable until that edge. cmd_ready_o depends only on FIFO
// occupancy and never on cmd_valid_i.
module npu_cmd_issuer #(
  parameter int DWidth     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_MAX   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [DWidth-1:0] cmd_addr_i,
  input  logic [DWidth-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWidth-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              cen_o,
  output logic              wen_o,
  output logic [DWidth-1:0] addr_o,
  output logic [DWidth-1:0] wdata_o,
  output logic [1:0]        dbg_state_o,
`ifdef NPU_CMD_ISSUER_PERF_EN
  output logic [31:0]       perf_busy_cycles_o,
  output logic [31:0]       perf_cmds_o,
`endif
  input  logic [DWidth-1:0] rdata_i
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

  localparam logic [AW:0]    PTR_ONE   = (AW+1)'(1);
  localparam logic [PCW-1:0] PCNT_ONE  = PCW'(1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Command FIFO storage and pointers (extra MSB distinguishes full/empty)
  logic [1:0]        r_fifo_op   [FIFO_DEPTH];
  logic [DWidth-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DWidth-1:0] r_fifo_data [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_head_op;
  logic [DWidth-1:0] w_head_addr;
  logic [DWidth-1:0] w_head_data;

  // FSM, working registers, bus and response registers
  state_t            r_state, w_state_d;
  logic [1:0]        r_op, w_op_d;
  logic [DWidth-1:0] r_waddr, w_waddr_d;
  logic [DWidth-1:0] r_mask, w_mask_d;
  logic [PCW-1:0]    r_poll_cnt, w_poll_d;
  logic              r_cen, w_cen_d;
  logic              r_wen, w_wen_d;
  logic [DWidth-1:0] r_addr, w_addr_d;
  logic [DWidth-1:0] r_wdata, w_wdata_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [DWidth-1:0] r_rsp_data, w_rsp_data_d;
  logic              r_rsp_err, w_rsp_err_d;
  logic              w_busy;
  logic              w_match;

  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_push      = cmd_valid_i && !w_full;
  assign w_head_op   = r_fifo_op[r_rd_ptr[AW-1:0]];
  assign w_head_addr = r_fifo_addr[r_rd_ptr[AW-1:0]];
  assign w_head_data = r_fifo_data[r_rd_ptr[AW-1:0]];
  assign w_match     = (rdata_i & r_mask) != '0;
  assign w_busy      = !w_empty || (r_state != S_IDLE);

  assign cmd_ready_o = !w_full;
  assign busy_o      = w_busy;
  assign cen_o       = r_cen;
  assign wen_o       = r_wen;
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;
  assign dbg_state_o = r_state;

  // FIFO entry storage: written on push only, contents need no reset
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr[AW-1:0]]   <= cmd_op_i;
      r_fifo_addr[r_wr_ptr[AW-1:0]] <= cmd_addr_i;
      r_fifo_data[r_wr_ptr[AW-1:0]] <= cmd_data_i;
    end
  end

  // FIFO pointers: advance on push and pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Next-state and next-output decode; bus outputs are set up on the
  // transition into ISSUE so the access is visible in the ISSUE cycle.
  always_comb begin
    w_state_d     = r_state;
    w_pop         = 1'b0;
    w_op_d        = r_op;
    w_waddr_d     = r_waddr;
    w_mask_d      = r_mask;
    w_poll_d      = r_poll_cnt;
    w_cen_d       = 1'b1;
    w_wen_d       = 1'b1;
    w_addr_d      = r_addr;
    w_wdata_d     = r_wdata;
    w_rsp_valid_d = r_rsp_valid;
    w_rsp_data_d  = r_rsp_data;
    w_rsp_err_d   = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_op_d    = w_head_op;
          w_waddr_d = w_head_addr;
          w_mask_d  = w_head_data;
          w_poll_d  = '0;
          if (w_head_op == OP_RSVD) begin
            w_state_d     = S_RESP;
            w_rsp_valid_d = 1'b1;
            w_rsp_data_d  = '0;
            w_rsp_err_d   = 1'b1;
          end else begin
            w_state_d = S_ISSUE;
            w_cen_d   = 1'b0;
            w_addr_d  = w_head_addr;
            if (w_head_op == OP_WRITE) begin
              w_wen_d   = 1'b0;
              w_wdata_d = w_head_data;
            end
          end
        end
      end
      S_ISSUE: begin
        w_state_d = (r_op == OP_WRITE) ? S_IDLE : S_RDWAIT;
      end
      S_RDWAIT: begin
        if (r_op == OP_READ || (r_op == OP_POLL && w_match)) begin
          w_state_d     = S_RESP;
          w_rsp_valid_d = 1'b1;
          w_rsp_data_d  = rdata_i;
          w_rsp_err_d   = 1'b0;
        end else if (r_poll_cnt == POLL_LAST) begin
          w_state_d     = S_RESP;
          w_rsp_valid_d = 1'b1;
          w_rsp_data_d  = rdata_i;
          w_rsp_err_d   = 1'b1;
        end else begin
          w_poll_d  = r_poll_cnt + PCNT_ONE;
          w_state_d = S_ISSUE;
          w_cen_d   = 1'b0;
          w_addr_d  = r_waddr;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_d = 1'b0;
          w_state_d     = S_IDLE;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_d;
  end

  // Working registers for the command being executed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op       <= OP_WRITE;
      r_waddr    <= '0;
      r_mask     <= '0;
      r_poll_cnt <= '0;
    end else begin
      r_op       <= w_op_d;
      r_waddr    <= w_waddr_d;
      r_mask     <= w_mask_d;
      r_poll_cnt <= w_poll_d;
    end
  end

  // Registered NPU bus outputs and response outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cen       <= 1'b1;
      r_wen       <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_cen       <= w_cen_d;
      r_wen       <= w_wen_d;
      r_addr      <= w_addr_d;
      r_wdata     <= w_wdata_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_data  <= w_rsp_data_d;
      r_rsp_err   <= w_rsp_err_d;
    end
  end

`ifdef NPU_CMD_ISSUER_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_cmds;

  assign perf_busy_cycles_o = r_perf_busy;
  assign perf_cmds_o        = r_perf_cmds;

  // Saturating counters of busy cycles and popped commands
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_busy <= '0;
      r_perf_cmds <= '0;
    end else begin
      if (w_busy && (r_perf_busy != '1)) r_perf_busy <= r_perf_busy + 32'd1;
      if (w_pop && (r_perf_cmds != '1))  r_perf_cmds <= r_perf_cmds + 32'd1;
    end
  end
`else
  // Without the performance feature there are no counters to maintain.
`endif

endmodule

// File: tb/tb_npu_cmd_issuer.sv
// Bench for npu_cmd_issuer: directed steps followed by randomized command
// batches, checked against a shadow register map and rule-level response model.
module tb_npu_cmd_issuer;

  localparam int          TB_POLL_MAX = 8;
  localparam logic [31:0] POLL_A      = 32'h30;
  localparam logic [1:0]  OP_WRITE    = 2'd0;
  localparam logic [1:0]  OP_READ     = 2'd1;
  localparam logic [1:0]  OP_POLL     = 2'd2;
  localparam logic [1:0]  OP_RSVD     = 2'd3;
  localparam int          BUDGET      = 400;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        cen_o;
  logic        wen_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [1:0]  dbg_state_o;
  logic [31:0] rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  npu_cmd_issuer #(
    .DWidth    (32),
    .FIFO_DEPTH(4),
    .POLL_MAX  (TB_POLL_MAX)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready_o),
    .cmd_op_i   (cmd_op),
    .cmd_addr_i (cmd_addr),
    .cmd_data_i (cmd_data),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o),
    .busy_o     (busy_o),
    .cen_o      (cen_o),
    .wen_o      (wen_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .dbg_state_o(dbg_state_o),
    .rdata_i    (rdata)
  );

  // ---------------- NPU slave model ----------------
  logic [31:0] npu_mem [logic [31:0]];
  logic [63:0] bus_wr_q [$];
  int          n_bus_rd;
  int          n_bus_wr;
  int          n_rsp_cycles;
  int          poll_reads;
  int          poll_thresh;
  logic [31:0] poll_val;

  // POLL_A returns 0 for the first poll_thresh reads, then poll_val.
  always @(posedge clk) begin
    if (rst_n && cen_o === 1'b0) begin
      if (wen_o === 1'b0) begin
        npu_mem[addr_o] = wdata_o;
        bus_wr_q.push_back({addr_o, wdata_o});
        n_bus_wr++;
      end else begin
        n_bus_rd++;
        if (addr_o == POLL_A) begin
          rdata <= (poll_reads >= poll_thresh) ? poll_val : 32'h0;
          poll_reads++;
        end else begin
          rdata <= npu_mem.exists(addr_o) ? npu_mem[addr_o] : 32'h0;
        end
      end
    end
    if (rsp_valid_o === 1'b1) n_rsp_cycles++;
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q [$];
  logic [63:0] exp_wr_q [$];
  logic [31:0] exp_mem [logic [31:0]];
  int          n_vec;
  int          n_err;

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    while (cmd_ready_o !== 1'b1 && b < BUDGET) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= BUDGET) chk("push_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic [32:0] exp, input int stall, input string tag);
    int b;
    b = 0;
    while (rsp_valid_o !== 1'b1 && b < BUDGET) begin
      @(posedge clk); #1;
      b++;
    end
    chk({tag, "_valid"}, 64'(rsp_valid_o), 64'(1));
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_hold"}, 64'({rsp_err_o, rsp_data_o}), 64'(exp));
      @(posedge clk); #1;
    end
    chk(tag, 64'({rsp_err_o, rsp_data_o}), 64'(exp));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, 64'(rsp_valid_o), 64'(0));
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy_o !== 1'b0 && b < BUDGET) begin
      @(posedge clk); #1;
      b++;
    end
    chk("idle_timeout", 64'(busy_o), 64'(0));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          rd0;
    int          wr0;
    int          rc0;
    int          exp_rd;
    int          k;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] v;
    logic [32:0] e;

    n_vec = 0; n_err = 0;
    n_bus_rd = 0; n_bus_wr = 0; n_rsp_cycles = 0;
    poll_reads = 0; poll_thresh = 0; poll_val = 32'h0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_addr = 32'h0; cmd_data = 32'h0; rsp_ready = 1'b0; rdata = 32'h0;

    // Reset values
    step(3);
    chk("rst_cen", 64'(cen_o), 64'(1));
    chk("rst_wen", 64'(wen_o), 64'(1));
    chk("rst_addr", 64'(addr_o), 64'(0));
    chk("rst_wdata", 64'(wdata_o), 64'(0));
    chk("rst_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_data_o}), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_ready", 64'(cmd_ready_o), 64'(1));
    rst_n = 1'b1;
    step(2);

    // WRITE 0x10 <- DEADBEEF: single bus cycle at t+2, no response
    wr0 = n_bus_wr; rc0 = n_rsp_cycles;
    exp_mem[32'h10] = 32'hDEADBEEF;
    push(OP_WRITE, 32'h10, 32'hDEADBEEF);
    chk("wr_t1_cen", 64'(cen_o), 64'(1));
    step(1);
    chk("wr_t2_bus", 64'({cen_o, wen_o, addr_o, wdata_o}), {2'b00, 32'h10, 32'hDEADBEEF});
    step(1);
    chk("wr_t3_bus", 64'({cen_o, wen_o, addr_o, wdata_o}), {2'b11, 32'h10, 32'hDEADBEEF});
    wait_idle();
    chk("wr_count", 64'(n_bus_wr - wr0), 64'(1));
    chk("wr_no_rsp", 64'(n_rsp_cycles - rc0), 64'(0));

    // READ 0x20 = 0x1234: response at t+4, held 5 cycles
    npu_mem[32'h20] = 32'h1234;
    exp_mem[32'h20] = 32'h1234;
    push(OP_READ, 32'h20, 32'h0);
    chk("rd_t1_valid", 64'(rsp_valid_o), 64'(0));
    step(1);
    chk("rd_t2_bus", 64'({cen_o, wen_o, addr_o}), 64'({2'b01, 32'h20}));
    step(1);
    chk("rd_t3_valid", 64'({rsp_valid_o, cen_o}), 64'(2'b01));
    step(1);
    chk("rd_t4_valid", 64'(rsp_valid_o), 64'(1));
    expect_rsp({1'b0, 32'h1234}, 5, "rd_rsp");
    wait_idle();

    // POLL 0x30 mask 1: three zero reads then a match
    rd0 = n_bus_rd; poll_reads = 0; poll_thresh = 3; poll_val = 32'h1;
    push(OP_POLL, POLL_A, 32'h1);
    expect_rsp({1'b0, 32'h1}, 0, "poll_match");
    wait_idle();
    chk("poll_match_reads", 64'(n_bus_rd - rd0), 64'(4));

    // POLL matching on the final allowed read: no timeout
    rd0 = n_bus_rd; poll_reads = 0; poll_thresh = TB_POLL_MAX - 1; poll_val = 32'h1;
    push(OP_POLL, POLL_A, 32'h1);
    expect_rsp({1'b0, 32'h1}, 1, "poll_last");
    wait_idle();
    chk("poll_last_reads", 64'(n_bus_rd - rd0), 64'(TB_POLL_MAX));

    // POLL that never matches: timeout after POLL_MAX reads
    rd0 = n_bus_rd; poll_reads = 0; poll_thresh = 1000; poll_val = 32'h1;
    push(OP_POLL, POLL_A, 32'h1);
    expect_rsp({1'b1, 32'h0}, 2, "poll_tmo");
    wait_idle();
    chk("poll_tmo_reads", 64'(n_bus_rd - rd0), 64'(TB_POLL_MAX));

    // POLL with zero mask on nonzero data: always times out, returns data
    rd0 = n_bus_rd;
    push(OP_POLL, 32'h20, 32'h0);
    expect_rsp({1'b1, 32'h1234}, 0, "poll_mask0");
    wait_idle();
    chk("poll_mask0_reads", 64'(n_bus_rd - rd0), 64'(TB_POLL_MAX));

    // Fill the FIFO while a READ response is stalled
    rd0 = n_bus_rd; wr0 = n_bus_wr;
    push(OP_READ, 32'h20, 32'h0);
    step(4);
    chk("fill_stalled", 64'(rsp_valid_o), 64'(1));
    push(OP_RSVD, 32'h0, 32'h0);
    push(OP_WRITE, 32'h40, 32'hA5A50001);
    exp_mem[32'h40] = 32'hA5A50001;
    push(OP_READ, 32'h40, 32'h0);
    push(OP_READ, 32'h20, 32'h0);
    chk("fill_full", 64'(cmd_ready_o), 64'(0));
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 32'h50; cmd_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("fill_blocked", 64'(cmd_ready_o), 64'(0));
    end
    cmd_valid = 1'b0;
    expect_rsp({1'b0, 32'h1234}, 1, "fill_r0");
    expect_rsp({1'b1, 32'h0}, 2, "fill_rsvd");
    expect_rsp({1'b0, 32'hA5A50001}, 0, "fill_r40");
    expect_rsp({1'b0, 32'h1234}, 3, "fill_r20");
    wait_idle();
    chk("fill_no_extra", 64'(rsp_valid_o), 64'(0));
    chk("fill_reads", 64'(n_bus_rd - rd0), 64'(3));
    chk("fill_writes", 64'(n_bus_wr - wr0), 64'(1));

    // Reset in the middle of a POLL: abandoned without a response
    poll_reads = 0; poll_thresh = 1000; poll_val = 32'h1;
    push(OP_POLL, POLL_A, 32'h1);
    step(5);
    chk("mid_poll_cen", 64'(cen_o), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cen", 64'(cen_o), 64'(1));
    chk("mid_rst_valid", 64'(rsp_valid_o), 64'(0));
    chk("mid_rst_ready", 64'(cmd_ready_o), 64'(1));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    step(2);
    rst_n = 1'b1;
    rc0 = n_rsp_cycles; rd0 = n_bus_rd + n_bus_wr;
    step(30);
    chk("post_rst_no_rsp", 64'(n_rsp_cycles - rc0), 64'(0));
    chk("post_rst_no_bus", 64'(n_bus_rd + n_bus_wr - rd0), 64'(0));
    chk("post_rst_busy", 64'(busy_o), 64'(0));

    // Randomized batches of up to FIFO_DEPTH commands
    for (int bt = 0; bt < 24; bt++) begin
      k = $urandom_range(1, 4);
      rd0 = n_bus_rd; exp_rd = 0;
      bus_wr_q.delete(); exp_wr_q.delete(); exp_q.delete();
      for (int i = 0; i < k; i++) begin
        op = 2'($urandom_range(0, 3));
        a  = 32'h100 + 32'(4 * $urandom_range(0, 3));
        d  = $urandom;
        if (op == OP_POLL && $urandom_range(0, 3) == 0) d = 32'h0;
        case (op)
          OP_WRITE: begin
            exp_mem[a] = d;
            exp_wr_q.push_back({a, d});
          end
          OP_READ: begin
            exp_q.push_back({1'b0, shadow_rd(a)});
            exp_rd += 1;
          end
          OP_POLL: begin
            v = shadow_rd(a);
            if ((v & d) != 32'h0) begin
              exp_q.push_back({1'b0, v});
              exp_rd += 1;
            end else begin
              exp_q.push_back({1'b1, v});
              exp_rd += TB_POLL_MAX;
            end
          end
          default: exp_q.push_back({1'b1, 32'h0});
        endcase
        push(op, a, d);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        expect_rsp(e, $urandom_range(0, 3), "rand_rsp");
      end
      wait_idle();
      chk("rand_rd_cnt", 64'(n_bus_rd - rd0), 64'(exp_rd));
      chk("rand_wr_cnt", 64'(bus_wr_q.size()), 64'(exp_wr_q.size()));
      while (exp_wr_q.size() > 0 && bus_wr_q.size() > 0) begin
        chk("rand_wr_bus", bus_wr_q.pop_front(), exp_wr_q.pop_front());
      end
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
